// File: rtl/tone_pkg.sv
// ============================================================================
// Module      : tone_pkg
// Description : Shared constants, FSM encodings and level clamp for tone_generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int DIV_ITER = 32;
    localparam int DIV_LAT  = 34;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clamp_level(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_div.sv
// ============================================================================
// Module      : serial_div
// Description : 32/33-bit restoring unsigned divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_div
    import tone_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [32:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [32:0] rem;
    logic [31:0] quo;
    logic [32:0] dvs;
    logic [5:0]  iter;
    logic        active;

    logic [33:0] shifted;
    logic        fits;
    logic [32:0] rem_next;

    // The true remainder is always below the divisor, so the 33-bit modular
    // difference is exact whenever the subtraction is taken.
    always_comb begin
        shifted  = {rem, quo[31]};
        fits     = shifted[33] | (shifted[32:0] >= dvs);
        rem_next = fits ? (shifted[32:0] - dvs) : shifted[32:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            iter   <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem    <= '0;
                quo    <= dividend;
                dvs    <= divisor;
                iter   <= '0;
                active <= 1'b1;
            end else if (active) begin
                rem  <= rem_next;
                quo  <= {quo[30:0], fits};
                iter <= iter + 6'd1;
                if (iter == 6'(DIV_ITER - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign quotient = (dvs == '0) ? '0 : quo;

endmodule

`default_nettype wire

// File: rtl/tone_generator.sv
// ============================================================================
// Module      : tone_generator
// Description : Square-wave test tone around MEAN at a requested frequency.
//               Optional macro NOISE_EN adds LFSR dither of -8..+7 to the output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_generator
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int DATA_W = 12,
    parameter int MEAN   = 2048,
    parameter int AMP    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       freq_in,
    input  logic              load,
    output logic              busy,
    output logic              running,
    output logic              sync,
    output logic [DATA_W-1:0] data
);

    localparam int LVL_MAX = (1 << DATA_W) - 1;
    localparam int LVL_HI  = MEAN + AMP;
    localparam int LVL_LO  = MEAN - AMP;

    logic [1:0]  state, state_n;
    logic [31:0] freq_r, freq_n;
    logic [31:0] half, half_n;
    logic [31:0] cnt, cnt_n;
    logic        phase, phase_n;
    logic        running_n, sync_n, busy_n;
    logic        start, start_n;
    logic [DATA_W-1:0] data_n;
    logic        div_done;
    logic [31:0] quotient;
    int          noise;
    int          level;

    serial_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (32'(CLK_HZ)),
        .divisor  ({freq_r, 1'b0}),
        .done     (div_done),
        .quotient (quotient)
    );

`ifdef NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign noise = int'($signed(lfsr[3:0]));
`else
    assign noise = 0;
`endif

    always_comb begin
        state_n   = state;
        freq_n    = freq_r;
        half_n    = half;
        cnt_n     = cnt;
        phase_n   = phase;
        running_n = running;
        sync_n    = 1'b0;
        busy_n    = busy;
        start_n   = 1'b0;

        if (load && !busy) begin
            freq_n  = freq_in;
            state_n = ST_DIV;
            busy_n  = 1'b1;
            start_n = 1'b1;
        end

        // The old waveform keeps running through DIV until the new half lands
        if (div_done) begin
            busy_n = 1'b0;
            cnt_n  = '0;
            if (freq_r == '0) begin
                state_n   = ST_IDLE;
                running_n = 1'b0;
                phase_n   = 1'b0;
            end else begin
                state_n   = ST_RUN;
                half_n    = (quotient == '0) ? 32'd1 : quotient;
                running_n = 1'b1;
                phase_n   = 1'b1;
                sync_n    = 1'b1;
            end
        end else if (running) begin
            if (cnt == half - 32'd1) begin
                cnt_n   = '0;
                phase_n = ~phase;
                sync_n  = ~phase;
            end else begin
                cnt_n = cnt + 32'd1;
            end
        end

        level  = running_n ? (phase_n ? LVL_HI : LVL_LO) : MEAN;
        data_n = DATA_W'(clamp_level(level + noise, LVL_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            freq_r  <= '0;
            half    <= '0;
            cnt     <= '0;
            phase   <= 1'b0;
            running <= 1'b0;
            sync    <= 1'b0;
            busy    <= 1'b0;
            start   <= 1'b0;
            data    <= DATA_W'(MEAN);
        end else begin
            state   <= state_n;
            freq_r  <= freq_n;
            half    <= half_n;
            cnt     <= cnt_n;
            phase   <= phase_n;
            running <= running_n;
            sync    <= sync_n;
            busy    <= busy_n;
            start   <= start_n;
            data    <= data_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tone_generator.sv
// ============================================================================
// Module      : tb_tone_generator
// Description : Self-checking bench for tone_generator (reduced CLK_HZ).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_generator;

    localparam int CLK_HZ = 100000;
    localparam int HI     = 3072;
    localparam int LO     = 1024;
    localparam int MID    = 2048;
    localparam int LIMIT  = 40000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] freq_in = '0;
    logic        load = 1'b0;
    logic        busy;
    logic        running;
    logic        sync;
    logic [11:0] data;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];

    typedef struct {
        logic [31:0] freq;
        logic        run;
        int          half;
    } vec_t;

    vec_t vecs[7];

    tone_generator #(
        .CLK_HZ (CLK_HZ),
        .DATA_W (12),
        .MEAN   (2048),
        .AMP    (1024)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .freq_in (freq_in),
        .load    (load),
        .busy    (busy),
        .running (running),
        .sync    (sync),
        .data    (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse load, then count busy cycles; optionally pulse a second load n cycles in.
    task automatic load_and_wait(input logic [31:0] f, input int extra_at,
                                 input logic [31:0] extra_f,
                                 output int n, output logic all_run);
        @(negedge clk);
        load = 1'b1;
        freq_in = f;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        all_run = 1'b1;
        while (busy && n < 100) begin
            n++;
            if (!running) all_run = 1'b0;
            if (n == extra_at) begin
                load = 1'b1;
                freq_in = extra_f;
            end
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    // Called on the first cycle after busy falls; measures one full period.
    task automatic measure(input string tag);
        int exp_half;
        int hi_n;
        int lo_n;
        logic sync_bad;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
            return;
        end
        exp_half = exp_q.pop_front();
        check({tag, "_start_sync"}, sync, 1);
        check({tag, "_start_data"}, data, HI);
        check({tag, "_running"}, running, 1);
        hi_n = 1;
        sync_bad = 1'b0;
        @(negedge clk);
        while (data == 12'(HI) && hi_n < LIMIT) begin
            if (sync) sync_bad = 1'b1;
            hi_n++;
            @(negedge clk);
        end
        check({tag, "_low_level"}, data, LO);
        lo_n = 0;
        while (data == 12'(LO) && lo_n < LIMIT) begin
            if (sync) sync_bad = 1'b1;
            lo_n++;
            @(negedge clk);
        end
        check({tag, "_high_len"}, hi_n, exp_half);
        check({tag, "_low_len"}, lo_n, exp_half);
        check({tag, "_next_sync"}, sync, 1);
        check({tag, "_next_high"}, data, HI);
        check({tag, "_stray_sync"}, sync_bad, 0);
    endtask

    initial begin
        int n;
        logic all_run;
        logic idle_bad;

        vecs[0] = '{32'd1000,     1'b1, 50};
        vecs[1] = '{32'd7,        1'b1, 7142};
        vecs[2] = '{32'd50000,    1'b1, 1};
        vecs[3] = '{32'd50001,    1'b1, 1};
        vecs[4] = '{32'd40000000, 1'b1, 1};
        vecs[5] = '{32'd3,        1'b1, 16666};
        vecs[6] = '{32'd0,        1'b0, 0};

        repeat (3) @(negedge clk);
        check("reset_data", data, MID);
        check("reset_busy", busy, 0);
        check("reset_running", running, 0);
        check("reset_sync", sync, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_data", data, MID);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].run) exp_q.push_back(vecs[i].half);
            load_and_wait(vecs[i].freq, 0, '0, n, all_run);
            check($sformatf("v%0d_busy_len", i), n, tone_pkg::DIV_LAT);
            check($sformatf("v%0d_running", i), running, vecs[i].run);
            if (vecs[i].run) begin
                measure($sformatf("v%0d", i));
            end else begin
                check("stop_old_wave_kept", all_run, 1);
                idle_bad = 1'b0;
                for (int k = 0; k < 60; k++) begin
                    if (data != 12'(MID) || sync || running) idle_bad = 1'b1;
                    @(negedge clk);
                end
                check("stop_idle_steady", idle_bad, 0);
            end
        end

        // Second load ten cycles into busy must be dropped
        exp_q.push_back(50);
        load_and_wait(32'd1000, 10, 32'd7, n, all_run);
        check("ignored_busy_len", n, tone_pkg::DIV_LAT);
        measure("ignored");

        // Load on the cycle busy falls must be dropped
        load_and_wait(32'd50001, 34, 32'd7, n, all_run);
        check("edge_busy_len", n, tone_pkg::DIV_LAT);
        check("edge_busy_after0", busy, 0);
        @(negedge clk);
        check("edge_busy_after1", busy, 0);
        check("edge_running", running, 1);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        check("arst_data", data, MID);
        check("arst_running", running, 0);
        check("arst_busy", busy, 0);
        check("arst_sync", sync, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_resume_running", running, 0);
        check("arst_no_resume_data", data, MID);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Test-signal source for the frequency-measurement path. It produces 12-bit square-wave samples centred on a programmable mean at a requested frequency in Hz.
- It is the opposite end of the frequency meter: it turns a frequency word into samples, where the meter turns samples into a frequency word.
- Sits between the control/config logic and the DAC, or loops back into the meter input for self-test.
- Half-period length is computed by an internal serial divider.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz (dividend).
- DATA_W, 12, sample width.
- MEAN, 2048, output mid-level (unsigned).
- AMP, 1024, peak deviation from MEAN. MEAN+AMP must be ≤ 2^DATA_W-1 and MEAN-AMP ≥ 0.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- freq_in, input, 32, requested frequency in Hz; sampled only on an accepted load.
- load, input, 1, one-cycle request to apply freq_in.
- busy, output, 1, divider running; loads are ignored while high.
- running, output, 1, waveform active (last applied freq ≠ 0).
- sync, output, 1, one-cycle pulse on the first cycle of every high phase.
- data, output, DATA_W, sample out, registered.

Behaviour:
- Reset (async, rst_n=0):
  - data=MEAN, busy=0, running=0, sync=0.
  - half=0, cnt=0, phase=LOW, FSM=IDLE.
- FSM states: IDLE, DIV, RUN.
  - IDLE/RUN + load & !busy → DIV. freq_in is latched and busy=1 from the next cycle.
  - load while busy=1 is dropped; no queueing.
  - DIV computes half = floor(CLK_HZ / (2*freq)). The divisor is 33 bits wide, so 2*freq never overflows.
  - The divider uses exactly 32 iterations. busy is high for exactly 34 cycles (start + 32 iterations + result).
- DIV completes on the edge busy falls:
  - If freq==0: FSM→IDLE, running=0, data=MEAN from the next cycle.
  - Else if the quotient is 0 (freq > CLK_HZ/2): half is clamped to 1.
  - Else: FSM→RUN, running=1, cnt=0, phase=HIGH, sync=1 for that cycle, data=MEAN+AMP.
- While in DIV, the previous waveform continues unchanged using the old half.
- RUN:
  - cnt increments each cycle.
  - At cnt==half-1: cnt←0 and phase toggles.
  - On the toggle to HIGH, sync=1 for one cycle.
  - Output: data = MEAN+AMP when HIGH, MEAN-AMP when LOW. Period = 2*half cycles, duty exactly 50%.
- Arithmetic: half and cnt are 32-bit unsigned. Output sums are computed at DATA_W+1 bits and clamped to [0, 2^DATA_W-1].
- Reset mid-DIV or mid-RUN returns every output to its reset value immediately. There is no resume.
- load asserted on the same cycle busy falls is ignored. busy is still high in that cycle.

Optional Feature:
- Macro NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clock.
  - Its low 4 bits, taken as signed -8..+7, are added to data in both IDLE and RUN, with the same clamping.
  - Purpose: exercise the meter's mean-crossing robustness.
- Undefined: no LFSR; data is exactly as above.

Decomposition:
- Package tone_pkg:
  - FSM state enum (IDLE/DIV/RUN).
  - DIV_ITER=32 and DIV_LAT=34.
  - LFSR seed and tap constants.
  - Clamp helper function.
- Sub-module serial_div:
  - 32/33-bit restoring unsigned divider.
  - Ports: start, dividend, divisor, done, quotient.
  - Divide-by-zero returns quotient 0.

Test Plan:
- Reset, then load freq_in=1000 → busy high for 34 cycles. Then sync pulses every 50000 cycles; data=3072 for 25000 cycles and 1024 for 25000 cycles.
- Load freq_in=0 while running → old waveform continues for 34 cycles, then running=0, data=2048 constant, no sync.
- Load freq_in=40000000 → half clamped to 1; data alternates 3072/1024 every cycle and sync fires every 2 cycles.
- Load freq_in=3 → half=8333333 (truncated). Verify the sync spacing is 16666666 cycles.
- Second load pulsed 10 cycles into busy → ignored; the result matches the first freq_in only.
- Assert rst_n=0 mid-RUN for 1 cycle → data=2048, running=0, busy=0 immediately. With NOISE_EN, data stays within 2040..2055 while idle.
